// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline MEM stage (req 0) vs external loader port (req 1).
// Optional address range check is enabled with `define DMEM_ARB_BOUNDS_EN.
module dmem_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_WAIT  = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_ack,
    output logic [DATA_W-1:0] p_rdata,
    output logic              pipe_stall,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              x_ack,
    output logic [DATA_W-1:0] x_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    if (RD_LAT < 1) begin : g_bad_lat
        $error("RD_LAT must be >= 1");
    end
    if (MAX_WAIT < 1) begin : g_bad_wait
        $error("MAX_WAIT must be >= 1");
    end
    if (MEM_DEPTH < 1) begin : g_bad_depth
        $error("MEM_DEPTH must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0] x_rdata_q, x_rdata_d;
    logic              grant_x;
    logic              in_range;
    logic [ADDR_W-1:0] sel_addr;
`ifdef DMEM_ARB_BOUNDS_EN
    logic              oob_q, oob_d;
`endif

    // Arbitration: ext wins only when pipeline is idle or ext has starved
    always_comb begin
        grant_x  = x_req & (~p_req | (cnt_q == CW'(MAX_WAIT)));
        sel_addr = grant_x ? x_addr : p_addr;
`ifdef DMEM_ARB_BOUNDS_EN
        in_range = 32'(sel_addr) < 32'(MEM_DEPTH);
`else
        in_range = 1'b1;
`endif
    end

    // Next-state and datapath for the access sequencer
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        m_en_d    = 1'b0;
        m_we_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        p_rdata_d = p_rdata_q;
        x_rdata_d = x_rdata_q;
`ifdef DMEM_ARB_BOUNDS_EN
        oob_d     = oob_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!x_req || grant_x) begin
                    cnt_d = '0;
                end else if (p_req && cnt_q != CW'(MAX_WAIT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (p_req || x_req) begin
                    owner_d   = grant_x;
                    we_d      = grant_x ? x_we : p_we;
                    m_addr_d  = sel_addr;
                    m_wdata_d = grant_x ? x_wdata : p_wdata;
                    m_en_d    = in_range;
                    m_we_d    = we_d & in_range;
`ifdef DMEM_ARB_BOUNDS_EN
                    oob_d     = ~in_range;
`endif
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef DMEM_ARB_BOUNDS_EN
                if (oob_q) begin
                    state_d = S_ACK;
                    if (owner_q) x_rdata_d = '0;
                    else         p_rdata_d = '0;
                end else
`endif
                if (we_q) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_WAIT;
                    lat_d   = LW'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    if (owner_q) x_rdata_d = m_rdata;
                    else         p_rdata_d = m_rdata;
                    state_d = S_ACK;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered memory-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            lat_q     <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            p_rdata_q <= '0;
            x_rdata_q <= '0;
`ifdef DMEM_ARB_BOUNDS_EN
            oob_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            p_rdata_q <= p_rdata_d;
            x_rdata_q <= x_rdata_d;
`ifdef DMEM_ARB_BOUNDS_EN
            oob_q     <= oob_d;
`endif
        end
    end

    assign p_ack      = (state_q == S_ACK) & ~owner_q;
    assign x_ack      = (state_q == S_ACK) & owner_q;
    assign pipe_stall = p_req & ~p_ack;
    assign p_rdata    = p_rdata_q;
    assign x_rdata    = x_rdata_q;
    assign m_en       = m_en_q;
    assign m_we       = m_we_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
`ifdef DMEM_ARB_BOUNDS_EN
    assign err        = (state_q == S_ACK) & oob_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: default instance plus an RD_LAT=3 instance.
// Checks latency, arbitration fairness, reset abort and range handling.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_req, p_we, x_req, x_we;
    logic [8:0]  p_addr, x_addr;
    logic [31:0] p_wdata, x_wdata;
    logic        p_ack, x_ack, pipe_stall, m_en, m_we, err;
    logic [31:0] p_rdata, x_rdata, m_wdata, m_rdata;
    logic [8:0]  m_addr;

    logic        l3_p_req, l3_p_ack, l3_stall, l3_x_ack;
    logic        l3_m_en, l3_m_we, l3_err;
    logic [8:0]  l3_p_addr, l3_m_addr;
    logic [31:0] l3_p_rdata, l3_x_rdata, l3_m_wdata, l3_m_rdata;

    logic [31:0] mem [0:511];
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_rdata(p_rdata), .pipe_stall(pipe_stall),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_ack(x_ack), .x_rdata(x_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .err(err)
    );

    dmem_arbiter #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .p_req(l3_p_req), .p_we(1'b0), .p_addr(l3_p_addr),
        .p_wdata(32'h0),
        .p_ack(l3_p_ack), .p_rdata(l3_p_rdata), .pipe_stall(l3_stall),
        .x_req(1'b0), .x_we(1'b0), .x_addr(9'h0), .x_wdata(32'h0),
        .x_ack(l3_x_ack), .x_rdata(l3_x_rdata),
        .m_en(l3_m_en), .m_we(l3_m_we), .m_addr(l3_m_addr),
        .m_wdata(l3_m_wdata), .m_rdata(l3_m_rdata), .err(l3_err)
    );

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_p(input logic we, input logic [8:0] a,
                         input logic [31:0] d, input int lat);
        int c;
        bit got;
        step();
        p_req = 1'b1; p_we = we; p_addr = a; p_wdata = d;
        #1;
        c = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (p_ack) begin
                got = 1'b1;
                break;
            end
            step();
            #1;
            c++;
        end
        chk("run_p_lat", got ? c : -1, lat);
        step();
        p_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pa, both, cnt_at;
        bit xs;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[9'h040] = 32'h12345678;
        mem[9'h150] = 32'hCAFEF00D;
        reset = 1'b0;
        p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        x_req = 0; x_we = 0; x_addr = 0; x_wdata = 0;
        l3_p_req = 0; l3_p_addr = 0; l3_m_rdata = 32'hBAD0BAD0;
        repeat (2) step();
        #1;
        chk("rst_p_ack", p_ack, 0);
        chk("rst_x_ack", x_ack, 0);
        chk("rst_m_en", m_en, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_p_rdata", p_rdata, 0);
        chk("rst_x_rdata", x_rdata, 0);
        chk("rst_err", err, 0);
        step();
        reset = 1'b1;

        step();
        p_req = 1; p_we = 1; p_addr = 9'h010; p_wdata = 32'hDEADBEEF;
        #1;
        chk("t1_stall0", pipe_stall, 1);
        chk("t1_m_en0", m_en, 0);
        step(); #1;
        chk("t1_m_en1", m_en, 1);
        chk("t1_m_we1", m_we, 1);
        chk("t1_m_addr1", m_addr, 32'h010);
        chk("t1_m_wdata1", m_wdata, 32'hDEADBEEF);
        chk("t1_stall1", pipe_stall, 1);
        step(); #1;
        chk("t1_ack2", p_ack, 1);
        chk("t1_stall2", pipe_stall, 0);
        chk("t1_m_en2", m_en, 0);
        chk("t1_x_ack2", x_ack, 0);
        step();
        p_req = 0;
        #1;
        chk("t1_ack3", p_ack, 0);

        step();
        x_req = 1; x_we = 0; x_addr = 9'h040;
        #1;
        chk("t2_stall", pipe_stall, 0);
        step(); #1;
        chk("t2_m_en1", m_en, 1);
        chk("t2_m_we1", m_we, 0);
        chk("t2_m_addr1", m_addr, 32'h040);
        step(); #1;
        chk("t2_ack2", x_ack, 0);
        step(); #1;
        chk("t2_ack3", x_ack, 1);
        chk("t2_p_ack3", p_ack, 0);
        chk("t2_rdata3", x_rdata, 32'h12345678);
        chk("t2_p_rdata", p_rdata, 0);
        step();
        x_req = 0;
        #1;
        chk("t2_ack4", x_ack, 0);
        chk("t2_hold", x_rdata, 32'h12345678);

        run_p(1'b0, 9'h010, 32'h0, 3);
        #1;
        chk("rd_p_rdata", p_rdata, 32'hDEADBEEF);
        chk("rd_x_keep", x_rdata, 32'h12345678);

        step();
        p_req = 1; p_we = 1; p_addr = 9'h030; p_wdata = 32'h1;
        x_req = 1; x_we = 1; x_addr = 9'h031; x_wdata = 32'h2;
        #1;
        pa = 0; both = 0; xs = 0; cnt_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (p_ack && x_ack) both++;
            if (p_ack) pa++;
            if (x_ack) begin
                xs = 1;
                cnt_at = int'(u_dut.cnt_q);
                break;
            end
            step(); #1;
        end
        chk("t3_x_seen", xs, 1);
        chk("t3_p_first", pa, 4);
        chk("t3_cnt_clr", cnt_at, 0);
        chk("t3_both", both, 0);
        chk("t3_x_keep", x_rdata, 32'h12345678);
        step();
        x_req = 0;
        #1;
        xs = 0;
        for (int i = 0; i < 10; i++) begin
            if (p_ack) begin
                xs = 1;
                break;
            end
            step(); #1;
        end
        chk("t3_p_resume", xs, 1);
        step();
        p_req = 0;

        step();
        x_req = 1; x_we = 0; x_addr = 9'h150;
        #1;
        chk("t5_err0", err, 0);
        step(); #1;
`ifdef DMEM_ARB_BOUNDS_EN
        chk("t5_m_en", m_en, 0);
        step(); #1;
        chk("t5_ack", x_ack, 1);
        chk("t5_err", err, 1);
        chk("t5_rdata", x_rdata, 0);
`else
        chk("t5_m_en", m_en, 1);
        chk("t5_m_addr", m_addr, 32'h150);
        step(); #1;
        chk("t5_ack2", x_ack, 0);
        chk("t5_err2", err, 0);
        step(); #1;
        chk("t5_ack", x_ack, 1);
        chk("t5_err", err, 0);
        chk("t5_rdata", x_rdata, 32'hCAFEF00D);
`endif
        step();
        x_req = 0;
        #1;
        chk("t5_err_end", err, 0);
        chk("t5_ack_end", x_ack, 0);

        step();
        l3_p_req = 1; l3_p_addr = 9'h005;
        #1;
        chk("t6_ack0", l3_p_ack, 0);
        step(); #1;
        chk("t6_m_en1", l3_m_en, 1);
        chk("t6_m_addr1", l3_m_addr, 32'h005);
        step(); #1;
        chk("t6_ack2", l3_p_ack, 0);
        step(); #1;
        chk("t6_ack3", l3_p_ack, 0);
        step();
        l3_m_rdata = 32'h600DF00D;
        #1;
        chk("t6_ack4", l3_p_ack, 0);
        chk("t6_stall4", l3_stall, 1);
        step();
        l3_m_rdata = 32'hBAD0BAD0;
        #1;
        chk("t6_ack5", l3_p_ack, 1);
        chk("t6_rdata5", l3_p_rdata, 32'h600DF00D);
        step();
        l3_p_req = 0;
        #1;
        chk("t6_ack6", l3_p_ack, 0);
        chk("t6_hold", l3_p_rdata, 32'h600DF00D);

        step();
        p_req = 1; p_we = 0; p_addr = 9'h010;
        step();
        step();
        reset = 1'b0;
        p_req = 0;
        #1;
        chk("t4_p_ack", p_ack, 0);
        chk("t4_m_en", m_en, 0);
        chk("t4_m_addr", m_addr, 0);
        chk("t4_m_wdata", m_wdata, 0);
        chk("t4_p_rdata", p_rdata, 0);
        chk("t4_x_rdata", x_rdata, 0);
        chk("t4_l3_rdata", l3_p_rdata, 0);
        step(); #1;
        chk("t4_p_ack_r", p_ack, 0);
        step();
        reset = 1'b1;
        step(); #1;
        chk("t4_no_ack_p", p_ack, 0);
        chk("t4_no_ack_x", x_ack, 0);
        run_p(1'b1, 9'h021, 32'hA5A55A5A, 2);
        run_p(1'b0, 9'h021, 32'h0, 3);
        #1;
        chk("t4_rdata", p_rdata, 32'hA5A55A5A);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
